// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
// Word size, FSM state encoding and the access-legality check live here.
package dmem_pkg;

  localparam int unsigned DMEM_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // True when the byte address is not word aligned or lies past the last word.
  function automatic logic dmem_addr_err(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] word;
    word = addr / DMEM_WORD_BYTES;
    return ((addr % DMEM_WORD_BYTES) != 0) || (word >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the responder: synchronous write, combinational read.
// Deliberately unreset so the contents survive a pipeline reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, commits stores on
// acceptance, returns load data after READ_LATENCY cycles and flags bad addresses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

  dmem_state_t   state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic [31:0]   rdata_reg, rdata_next;
  logic          err_reg, err_next;

  logic          accept;
  logic          addr_err;
  logic [AW-1:0] req_idx;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;

  assign req_idx    = req_addr[AW+1:2];
  assign addr_err   = dmem_addr_err(req_addr, DEPTH_WORDS);
  assign req_ready  = (state_reg == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(req_wdata),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    mem_we     = 1'b0;
    mem_addr   = idx_reg;

    case (state_reg)
      IDLE: begin
        // The live address drives the array only during the accept cycle.
        mem_addr = req_idx;
        if (accept) begin
          if (addr_err) begin
            state_next = RESP;
            err_next   = 1'b1;
            rdata_next = 32'd0;
          end else if (req_we) begin
            mem_we     = 1'b1;
            state_next = RESP;
            err_next   = 1'b0;
            rdata_next = 32'd0;
          end else if (READ_LATENCY == 1) begin
            state_next = RESP;
            err_next   = 1'b0;
            rdata_next = mem_rdata;
          end else begin
            idx_next   = req_idx;
            cnt_next   = CNT_INIT;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          rdata_next = mem_rdata;
          err_next   = 1'b0;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
          rdata_next = 32'd0;
          err_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      idx_reg   <= '0;
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: four responders (latency 2, 1, 3, 15) against a word-array
// reference model; one line per transaction, one summary line at the end.
module tb_dmem_responder;

  localparam int NI = 4;
  localparam logic [15:0] LATS = {4'd15, 4'd3, 4'd1, 4'd2};

  logic        clk;
  logic        rst;
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_we     [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic        resp_valid [NI];
  logic        resp_ready [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err   [NI];

  logic [31:0] ref_mem [NI][256];
  logic        ref_ok  [NI][256];

  int tests;
  int fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      dmem_responder #(
        .DEPTH_WORDS (256),
        .READ_LATENCY(int'(LATS[gi*4 +: 4]))
      ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid[gi]),
        .req_ready (req_ready[gi]),
        .req_we    (req_we[gi]),
        .req_addr  (req_addr[gi]),
        .req_wdata (req_wdata[gi]),
        .resp_valid(resp_valid[gi]),
        .resp_ready(resp_ready[gi]),
        .resp_rdata(resp_rdata[gi]),
        .resp_err  (resp_err[gi])
      );
    end
  endgenerate

  function automatic int lat_of(input int k);
    return int'(LATS[k*4 +: 4]);
  endfunction

  // Wait (bounded) at negedges until instance k can accept.
  task automatic wait_ready(input int k, input string name, output logic ok);
    int cyc;
    cyc = 0;
    while (req_ready[k] !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    ok = (req_ready[k] === 1'b1);
    if (!ok) begin
      fails++;
      $display("[TB] FAIL %s inst%0d req_ready timeout got=%b want=1", name, k, req_ready[k]);
    end
  endtask

  // One full request/response handshake with checks against the model.
  task automatic do_txn(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, input string name);
    int cyc;
    logic ok, exp_err, chk_d;
    logic [31:0] exp_d, snap;
    int exp_lat;
    exp_err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd256);
    exp_lat = (exp_err || we) ? 1 : lat_of(k);
    chk_d   = 1'b1;
    exp_d   = 32'd0;
    if (!exp_err && !we) begin
      if (ref_ok[k][addr[9:2]]) exp_d = ref_mem[k][addr[9:2]];
      else chk_d = 1'b0;
    end
    wait_ready(k, name, ok);
    if (!ok) return;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    @(posedge clk);
    if (!exp_err && we) begin
      ref_mem[k][addr[9:2]] = wdata;
      ref_ok[k][addr[9:2]]  = 1'b1;
    end
    @(negedge clk);
    req_valid[k] = 1'b0;
    req_we[k]    = 1'b0;
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    cyc = 1;
    while (resp_valid[k] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (resp_valid[k] !== 1'b1 || cyc != exp_lat) begin
      fails++;
      $display("[TB] FAIL %s inst%0d latency got=%0d want=%0d", name, k, cyc, exp_lat);
      if (resp_valid[k] !== 1'b1) return;
    end
    tests++;
    if (resp_err[k] !== exp_err) begin
      fails++;
      $display("[TB] FAIL %s inst%0d resp_err got=%b want=%b", name, k, resp_err[k], exp_err);
    end
    if (chk_d) begin
      tests++;
      if (resp_rdata[k] !== exp_d) begin
        fails++;
        $display("[TB] FAIL %s inst%0d resp_rdata got=%h want=%h", name, k, resp_rdata[k], exp_d);
      end
    end
    snap = resp_rdata[k];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      tests++;
      if (resp_valid[k] !== 1'b1 || resp_rdata[k] !== snap || req_ready[k] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL %s inst%0d hold%0d valid/rdata/ready got=%b/%h/%b want=1/%h/0",
                 name, k, h, resp_valid[k], resp_rdata[k], req_ready[k], snap);
      end
    end
    resp_ready[k] = 1'b1;
    @(negedge clk);
    resp_ready[k] = 1'b0;
    tests++;
    if (resp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1 || resp_rdata[k] !== 32'd0 || resp_err[k] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s inst%0d post-consume valid/ready/rdata/err got=%b/%b/%h/%b want=0/1/0/0",
               name, k, resp_valid[k], req_ready[k], resp_rdata[k], resp_err[k]);
    end
    $display("[TB] %s inst%0d we=%b addr=%h wdata=%h lat=%0d err=%b rdata=%h",
             name, k, we, addr, wdata, cyc, exp_err, snap);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        tests++;
        if (req_ready[k] !== 1'b0 || resp_valid[k] !== 1'b0 || resp_rdata[k] !== 32'd0 || resp_err[k] !== 1'b0) begin
          fails++;
          $display("[TB] FAIL reset inst%0d ready/valid/rdata/err got=%b/%b/%h/%b want=0/0/0/0",
                   k, req_ready[k], resp_valid[k], resp_rdata[k], resp_err[k]);
        end
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      tests++;
      if (req_ready[k] !== 1'b1 || resp_valid[k] !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_release inst%0d ready/valid got=%b/%b want=1/0", k, req_ready[k], resp_valid[k]);
      end
    end
    $display("[TB] reset all instances");
  endtask

  task automatic test_round_trip();
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, "rt_store");
    do_txn(0, 1'b0, 32'h10, 32'h0, 0, "rt_load");
  endtask

  task automatic test_backpressure();
    do_txn(0, 1'b1, 32'h44, 32'hCAFE1234, 0, "bp_store");
    do_txn(0, 1'b0, 32'h44, 32'h0, 5, "bp_load");
  endtask

  task automatic test_errors();
    do_txn(0, 1'b1, 32'h0, 32'h11112222, 0, "err_init");
    do_txn(0, 1'b1, 32'h3, 32'hFFFFFFFF, 0, "err_store_mis");
    do_txn(0, 1'b0, 32'h0, 32'h0, 0, "err_readback");
    do_txn(0, 1'b0, 32'h400, 32'h0, 0, "err_load_oor");
    do_txn(2, 1'b0, 32'h402, 32'h0, 1, "err_load_both");
  endtask

  task automatic test_reset_midop(input int k);
    logic ok, seen;
    logic [31:0] v;
    v = $urandom;
    do_txn(k, 1'b1, 32'h20, v, 0, "mid_prep");
    wait_ready(k, "mid_load_accept", ok);
    if (!ok) return;
    req_valid[k] = 1'b1;
    req_we[k]    = 1'b0;
    req_addr[k]  = 32'h20;
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (resp_valid[k] === 1'b1) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_load_dropped inst%0d resp_valid seen=%b want=0", k, seen);
    end
    $display("[TB] mid_load_reset inst%0d dropped=%b", k, !seen);
    do_txn(k, 1'b0, 32'h20, 32'h0, 0, "mid_load_after");
    // Store already committed must survive a reset while its response waits.
    v = $urandom;
    wait_ready(k, "mid_store_accept", ok);
    if (!ok) return;
    req_valid[k] = 1'b1;
    req_we[k]    = 1'b1;
    req_addr[k]  = 32'h24;
    req_wdata[k] = v;
    @(posedge clk);
    ref_mem[k][9] = v;
    ref_ok[k][9]  = 1'b1;
    @(negedge clk);
    req_valid[k] = 1'b0;
    req_we[k]    = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (resp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_store_reset inst%0d valid/ready got=%b/%b want=0/1", k, resp_valid[k], req_ready[k]);
    end
    $display("[TB] mid_store_reset inst%0d data=%h", k, v);
    do_txn(k, 1'b0, 32'h24, 32'h0, 0, "mid_store_readback");
  endtask

  task automatic test_latency_sweep();
    for (int k = 1; k < NI; k++) begin
      do_txn(k, 1'b1, 32'h80, 32'hA5A50000 + k, 0, "sweep_store");
      do_txn(k, 1'b0, 32'h80, 32'h0, 0, "sweep_load");
      do_txn(k, 1'b0, 32'h7FC, 32'h0, 0, "sweep_err");
    end
  endtask

  task automatic test_random();
    logic we;
    logic [31:0] addr;
    int r;
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 20; n++) begin
        r  = $urandom_range(0, 9);
        we = 1'($urandom_range(0, 1));
        if (r == 0) addr = ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
        else if (r == 1) addr = ($urandom | 32'h400) & 32'hFFFF_FFFC;
        else addr = $urandom_range(0, 15) << 2;
        do_txn(k, we, addr, $urandom, $urandom_range(0, 3), "rand");
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    for (int k = 0; k < NI; k++) begin
      req_valid[k]  = 1'b0;
      req_we[k]     = 1'b0;
      req_addr[k]   = 32'd0;
      req_wdata[k]  = 32'd0;
      resp_ready[k] = 1'b0;
      for (int w = 0; w < 256; w++) begin
        ref_mem[k][w] = 32'd0;
        ref_ok[k][w]  = 1'b0;
      end
    end
    test_reset();
    test_round_trip();
    test_backpressure();
    test_errors();
    test_reset_midop(0);
    test_reset_midop(3);
    test_latency_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
